// File: rtl/spi_fifo.sv
// Single-clock FIFO with occupancy level, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module spi_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PTR_WIDTH  = 6
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  flush,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [PTR_WIDTH:0]    af_thresh,
  input  logic [PTR_WIDTH:0]    ae_thresh,
  input  logic                  err_clr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0]   LevelFull = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   LevelOne  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] PtrOne    = PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
  logic [PTR_WIDTH:0]    level_q, level_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_ok;
  logic wr_ok;

  // A read frees a slot on the same edge, so a full FIFO still takes a write.
  assign rd_ok = ren && !empty;
  assign wr_ok = wen && (!full || rd_ok);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    rdata_d     = rdata_q;
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_ok) begin
        wptr_d = wptr_q + PtrOne;
      end
      if (rd_ok) begin
        rptr_d  = rptr_q + PtrOne;
        rdata_d = mem[rptr_q];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + LevelOne;
        2'b01:   level_d = level_q - LevelOne;
        default: level_d = level_q;
      endcase
      // A new error wins over a coincident err_clr.
      if (wen && !wr_ok) begin
        overflow_d = 1'b1;
      end
      if (ren && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; clearing the pointers and level discards its contents.
  always_ff @(posedge pclk) begin
    if (preset_n && !flush && wr_ok) begin
      mem[wptr_q] <= wdata;
    end
  end

  assign level        = level_q;
  assign full         = (level_q == LevelFull);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);
  assign rdata        = rdata_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_spi_fifo.sv
// Self-checking bench for spi_fifo (DATA_WIDTH=32, PTR_WIDTH=2): directed scenarios
// plus randomized traffic compared against a queue-based reference model.
module tb_spi_fifo;

  localparam int DW = 32;
  localparam int PW = 2;
  localparam int DEPTH = 4;

  logic          pclk = 1'b0;
  logic          preset_n, flush, wen, ren, err_clr;
  logic [DW-1:0] wdata, rdata;
  logic [PW:0]   af_thresh, ae_thresh, level;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata;
  logic          m_ovf, m_unf;

  spi_fifo #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
    .pclk(pclk), .preset_n(preset_n), .flush(flush), .wen(wen), .wdata(wdata),
    .ren(ren), .rdata(rdata), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .err_clr(err_clr), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 pclk = ~pclk;

  // One clock edge: advance the model with the inputs the DUT saw, then settle.
  task automatic cycle();
    bit rd, wr, nov, nun;
    @(posedge pclk);
    if (!preset_n) begin
      q.delete();
      m_rdata = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      rd  = ren && (q.size() > 0);
      wr  = wen && ((q.size() < DEPTH) || rd);
      nov = wen && !wr;
      nun = ren && (q.size() == 0);
      if (rd) m_rdata = q.pop_front();
      if (wr) q.push_back(wdata);
      m_ovf = (m_ovf && !err_clr) || nov;
      m_unf = (m_unf && !err_clr) || nun;
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; wen = 0; ren = 0; err_clr = 0; wdata = '0;
  endtask

  task automatic test_reset();
    preset_n = 0; idle(); af_thresh = 0; ae_thresh = 0;
    m_ovf = 0; m_unf = 0; m_rdata = '0;
    cycle(); cycle();
    preset_n = 1;
    cycle();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b want=1", almost_empty); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL reset_af_t0 got=%b want=1", almost_full); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%0h want=0", rdata); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {overflow, underflow}); end
    af_thresh = 3; #1;
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af_t3 got=%b want=0", almost_full); end
  endtask

  task automatic test_fill_drain();
    wen = 1;
    for (int i = 0; i < 4; i++) begin
      wdata = 32'hA0 + i;
      cycle();
      checks++; if (level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got=%0d want=%0d", i, level, i + 1); end
    end
    wen = 0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b want=1", full); end
    ren = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (rdata !== 32'hA0 + i) begin errors++; $display("FAIL drain_rdata[%0d] got=%0h want=%0h", i, rdata, 32'hA0 + i); end
      checks++; if (level !== 3'(3 - i)) begin errors++; $display("FAIL drain_level[%0d] got=%0d want=%0d", i, level, 3 - i); end
    end
    ren = 0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b want=1", empty); end
  endtask

  task automatic test_overflow();
    wen = 1;
    for (int i = 0; i < 4; i++) begin
      wdata = 32'h10 + i;
      cycle();
    end
    wdata = 32'hFF;
    cycle();
    wen = 0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d want=4", level); end
    err_clr = 1;
    cycle();
    err_clr = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b want=0", overflow); end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] exp_seq [4];
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h12; exp_seq[2] = 32'h13; exp_seq[3] = 32'hB0;
    ren = 1; wen = 1; wdata = 32'hB0;
    cycle();
    wen = 0;
    checks++; if (rdata !== 32'h10) begin errors++; $display("FAIL fullrw_rdata got=%0h want=10", rdata); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullrw_level got=%0d want=4", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got=%b want=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (rdata !== exp_seq[i]) begin errors++; $display("FAIL fullrw_drain[%0d] got=%0h want=%0h", i, rdata, exp_seq[i]); end
    end
    ren = 0;
  endtask

  task automatic test_empty_rw();
    ren = 1; wen = 1; wdata = 32'hC0;
    cycle();
    wen = 0; ren = 0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL emptyrw_unf got=%b want=1", underflow); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL emptyrw_level got=%0d want=1", level); end
    checks++; if (rdata !== 32'hB0) begin errors++; $display("FAIL emptyrw_hold got=%0h want=b0", rdata); end
    ren = 1;
    cycle();
    ren = 0;
    checks++; if (rdata !== 32'hC0) begin errors++; $display("FAIL emptyrw_read got=%0h want=c0", rdata); end
    // New error and err_clr together: flag must stay set.
    ren = 1; err_clr = 1;
    cycle();
    ren = 0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_clr_race got=%b want=1", underflow); end
    cycle();
    err_clr = 0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr got=%b want=0", underflow); end
  endtask

  task automatic test_thresholds();
    logic [4:0] exp_ae, exp_af;
    exp_ae = 5'b00011; exp_af = 5'b11000;
    af_thresh = 3; ae_thresh = 1;
    for (int l = 0; l <= 4; l++) begin
      #1;
      checks++; if (almost_empty !== exp_ae[l]) begin errors++; $display("FAIL thr_ae[%0d] got=%b want=%b", l, almost_empty, exp_ae[l]); end
      checks++; if (almost_full !== exp_af[l]) begin errors++; $display("FAIL thr_af[%0d] got=%b want=%b", l, almost_full, exp_af[l]); end
      if (l < 4) begin
        wen = 1; wdata = 32'h50 + l;
        cycle();
        wen = 0;
      end
    end
  endtask

  task automatic test_flush_reset();
    wen = 1; wdata = 32'hEE;
    cycle();
    wen = 0; ren = 1;
    cycle();
    ren = 0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre_level got=%0d want=3", level); end
    flush = 1; wen = 1; wdata = 32'h77;
    cycle();
    flush = 0; wen = 0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level got=%0d want=0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b want=1", empty); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_ovf got=%b want=1", overflow); end
    checks++; if (rdata !== 32'h50) begin errors++; $display("FAIL flush_rdata got=%0h want=50", rdata); end
    wen = 1; wdata = 32'h61; cycle(); wdata = 32'h62; cycle();
    wen = 0;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL rst_pre_level got=%0d want=2", level); end
    preset_n = 0; ren = 1; err_clr = 0;
    cycle();
    preset_n = 1; ren = 0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d want=0", level); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%0h want=0", rdata); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wen   = ($urandom_range(0, 99) < 55);
      ren   = ($urandom_range(0, 99) < 50);
      wdata = $urandom();
      flush = ($urandom_range(0, 99) < 3);
      err_clr = !flush && ($urandom_range(0, 99) < 8);
      af_thresh = 3'($urandom_range(0, 4));
      ae_thresh = 3'($urandom_range(0, 4));
      cycle();
      checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level[%0d] got=%0d want=%0d", n, level, q.size()); end
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d] got=%0h want=%0h", n, rdata, m_rdata); end
      checks++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_flags[%0d] got=%b want=%b", n, {overflow, underflow}, {m_ovf, m_unf}); end
      checks++; if ({full, empty} !== {q.size() == DEPTH, q.size() == 0}) begin errors++; $display("FAIL rnd_fe[%0d] got=%b want=%b", n, {full, empty}, {q.size() == DEPTH, q.size() == 0}); end
      checks++; if ({almost_full, almost_empty} !== {q.size() >= int'(af_thresh), q.size() <= int'(ae_thresh)}) begin
        errors++;
        $display("FAIL rnd_almost[%0d] got=%b want=%b", n, {almost_full, almost_empty},
                 {q.size() >= int'(af_thresh), q.size() <= int'(ae_thresh)});
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_thresholds();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
